data_mem: RTL and testbench
===========================

# data_mem

Data memory for the MEM stage of the RV32I 5-stage pipeline. It takes the address, store data and control decoded upstream in EX/MEM. It performs byte, halfword and word stores into a synchronous-write array. Each cycle it produces the aligned, sign- or zero-extended load result `dm_data_mem`, which the MEM/WB register captures on the next rising edge.

## Interface
- `DEPTH`, default 256: number of 32-bit words; must be a power of two, at least 4.
- `ADDR_W`, default $clog2(DEPTH): word-index width; derived, not overridden.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_mem`  in  1  load instruction in MEM.
- `store_mem`  in  1  store instruction in MEM.
- `funct3_mem`  in  3  RV32I access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr_mem`  in  32  byte address (ALU result).
- `store_data_mem`  in  32  rs2 value, already forwarded.
- `dm_data_mem`  out  32  load result, combinational.
- `misalign_mem`  out  1  current access faults, combinational.
- `fault_sticky`  out  1  a faulting access has occurred since the last reset.

## Operation
- Word index is `addr_mem[ADDR_W+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Byte lane is `addr_mem[1:0]`.
- Fault conditions (`misalign_mem`=1). Each applies only when `load_mem` or `store_mem` is 1:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - funct3 not legal for the access type: stores accept 000, 001, 010 only; loads accept 000, 001, 010, 100, 101.
  - `load_mem` and `store_mem` both 1.
- Stores, when `store_mem`=1, no fault and `rst`=0, write on the rising edge:
  - SB writes byte lane addr[1:0] with store_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with store_data[15:0], little-endian.
  - SW writes the whole word.
  - Unselected lanes keep their value.
- Faulting stores write nothing.
- Loads (`load_mem`=1, no fault):
  - Read the indexed word asynchronously and select the byte or halfword at the lane.
  - B/H sign-extend from bit 7 or 15. BU/HU zero-extend. W passes the word unchanged.
- `dm_data_mem` is 32'h0 in these cases:
  - `load_mem`=0.
  - The load faults.
  - `rst`=1.
- Read during a write to the same word returns the pre-write contents. The new value is visible the cycle after the edge.
- `fault_sticky` sets on the rising edge after any cycle with `misalign_mem`=1 and `rst`=0. It stays set until `rst`.
- No stall or handshake: one access per cycle, never back-pressures.

## Timing
- Reset: on the rising edge with `rst`=1:
  - All DEPTH words become 0.
  - `fault_sticky` becomes 0.
  - Any store in that cycle is discarded.
- Output values while `rst` is high:
  - `dm_data_mem`=0.
  - `misalign_mem`=0.
  - After release, the array reads 0 everywhere.
- Load latency: 0 cycles combinational from address to `dm_data_mem`. It is registered by MEM/WB at the next edge.
- Store-to-load: a store at edge N is readable by a load presented in cycle N+1. No internal bypass is needed.
- `misalign_mem` is combinational from the current inputs. `fault_sticky` lags it by one edge.
- `rst` asserted mid-sequence: the store in the `rst` cycle is lost. The following cycle behaves as post-reset.

## Test plan
- SW then LW:
  - Stimulus: SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10.
  - Required: `dm_data_mem`=0xDEADBEEF; `fault_sticky`=0.
- Byte lanes and extension:
  - Stimulus: after the SW above, SB 0x80 at addr 0x11, then LW 0x10, LB 0x11, LBU 0x11 and LH 0x12.
  - Required: LW=0xDEAD80EF, LB=0xFFFFFF80, LBU=0x00000080, LH=0xFFFFDEAD.
- Misalignment:
  - Stimulus: SH addr 0x21, then LW addr 0x22.
  - Required:
    - `misalign_mem`=1 in both cycles.
    - `dm_data_mem`=0 for the LW.
    - Word 0x20 is unchanged (reads 0).
    - `fault_sticky`=1 from the edge after the SH.
- Wrap-around: with DEPTH=256, SW addr 0x400 data 0x12345678, then LW addr 0x0 returns 0x12345678.
- Same-cycle read/write:
  - Stimulus: a combined load+store cycle at 0x30.
  - Required: fault flagged, no write, output 0.
  - Separately, a store to 0x30 followed by a load to 0x30 returns the new data.
- Reset mid-operation:
  - Stimulus: fill words 0..3, assert `rst` for one cycle together with SW 0x0 data 0xFFFFFFFF.
  - Required: afterwards all words read 0 and `fault_sticky`=0.

Source files
------------

// File: rtl/data_mem.sv
// RV32I MEM-stage data memory: byte/half/word stores into a synchronous-write
// array, combinational aligned loads with sign/zero extension, fault flagging.
module data_mem #(
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_mem,
    input  logic        store_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] store_data_mem,
    output logic [31:0] dm_data_mem,
    output logic        misalign_mem,
    output logic        fault_sticky
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0]       mem_q [DEPTH];
    logic              sticky_q;
    logic              sticky_d;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              access;
    logic              half_bad;
    logic              word_bad;
    logic              st_f3_ok;
    logic              ld_f3_ok;
    logic              fault;
    logic              wr_en;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              unused_addr;

    assign idx         = addr_mem[ADDR_W+1:2];
    assign lane        = addr_mem[1:0];
    assign unused_addr = ^addr_mem[31:ADDR_W+2];

    assign access   = load_mem | store_mem;
    assign half_bad = (funct3_mem[1:0] == 2'b01) & addr_mem[0];
    assign word_bad = (funct3_mem == F3_W) & (lane != 2'b00);
    assign st_f3_ok = (funct3_mem == F3_B) | (funct3_mem == F3_H)
                    | (funct3_mem == F3_W);
    assign ld_f3_ok = st_f3_ok | (funct3_mem == F3_BU)
                    | (funct3_mem == F3_HU);

    // Faults are masked during reset so the pipeline sees a clean MEM stage.
    assign fault = ~rst & access & (
                       (load_mem & store_mem)
                     | (store_mem & ~st_f3_ok)
                     | (load_mem & ~ld_f3_ok)
                     | half_bad
                     | word_bad);

    assign misalign_mem = fault;
    assign fault_sticky = sticky_q;
    assign sticky_d     = sticky_q | fault;
    assign wr_en        = store_mem & ~fault & ~rst;

    always_comb begin
        be    = 4'b0000;
        wdata = store_data_mem;
        unique case (funct3_mem)
            F3_B: begin
                be    = 4'b0001 << lane;
                wdata = {4{store_data_mem[7:0]}};
            end
            F3_H: begin
                be    = addr_mem[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data_mem[15:0]}};
            end
            F3_W: begin
                be    = 4'b1111;
                wdata = store_data_mem;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data_mem;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word     = mem_q[idx];
        rd_byte     = rd_word[8*lane +: 8];
        rd_half     = addr_mem[1] ? rd_word[31:16] : rd_word[15:0];
        dm_data_mem = '0;
        if (load_mem & ~fault & ~rst) begin
            unique case (funct3_mem)
                F3_B:    dm_data_mem = {{24{rd_byte[7]}}, rd_byte};
                F3_H:    dm_data_mem = {{16{rd_half[15]}}, rd_half};
                F3_W:    dm_data_mem = rd_word;
                F3_BU:   dm_data_mem = {24'h0, rd_byte};
                F3_HU:   dm_data_mem = {16'h0, rd_half};
                default: dm_data_mem = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_data_mem;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        rst;
    logic        load_mem;
    logic        store_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] addr_mem;
    logic [31:0] store_data_mem;
    logic [31:0] dm_data_mem;
    logic        misalign_mem;
    logic        fault_sticky;

    typedef struct {
        int          id;
        logic [31:0] d;
        logic        m;
        logic        s;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   vec_id;

    data_mem #(.DEPTH(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_mem       (load_mem),
        .store_mem      (store_mem),
        .funct3_mem     (funct3_mem),
        .addr_mem       (addr_mem),
        .store_data_mem (store_data_mem),
        .dm_data_mem    (dm_data_mem),
        .misalign_mem   (misalign_mem),
        .fault_sticky   (fault_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic acc(input logic r, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic em, input logic es);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        load_mem       = ld;
        store_mem      = st;
        funct3_mem     = f3;
        addr_mem       = a;
        store_data_mem = wd;
        e.id = vec_id;
        e.d  = ed;
        e.m  = em;
        e.s  = es;
        exp_q.push_back(e);
        vec_id++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 3;
            if (dm_data_mem !== e.d) begin
                failures++;
                $display("FAIL vec%0d data got=%h exp=%h",
                         e.id, dm_data_mem, e.d);
            end
            if (misalign_mem !== e.m) begin
                failures++;
                $display("FAIL vec%0d misalign got=%b exp=%b",
                         e.id, misalign_mem, e.m);
            end
            if (fault_sticky !== e.s) begin
                failures++;
                $display("FAIL vec%0d sticky got=%b exp=%b",
                         e.id, fault_sticky, e.s);
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        vec_id         = 0;
        rst            = 1'b1;
        load_mem       = 1'b0;
        store_mem      = 1'b0;
        funct3_mem     = W;
        addr_mem       = '0;
        store_data_mem = '0;
        repeat (2) @(posedge clk);

        // reset: outputs forced quiet even for a faulting combo
        acc(1, 1, 0, W, 32'h0,  32'h0, 32'h0, 0, 0);
        acc(1, 1, 1, W, 32'h3,  32'h0, 32'h0, 0, 0);
        // SW then LW, byte lanes and extension
        acc(0, 0, 1, W,  32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        acc(0, 0, 1, B,  32'h11, 32'h12345680, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h10, 32'h0, 32'hDEAD80EF, 0, 0);
        acc(0, 1, 0, B,  32'h11, 32'h0, 32'hFFFFFF80, 0, 0);
        acc(0, 1, 0, BU, 32'h11, 32'h0, 32'h00000080, 0, 0);
        acc(0, 1, 0, H,  32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
        acc(0, 1, 0, HU, 32'h12, 32'h0, 32'h0000DEAD, 0, 0);
        acc(0, 1, 0, B,  32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
        acc(0, 1, 0, H,  32'h10, 32'h0, 32'hFFFF80EF, 0, 0);
        acc(0, 1, 0, HU, 32'h10, 32'h0, 32'h000080EF, 0, 0);
        // no access: bad address/funct3 is not a fault
        acc(0, 0, 0, W,  32'h23, 32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h20, 32'h0, 32'h0, 0, 0);
        // misalignment
        acc(0, 0, 1, H,  32'h21, 32'h0000AAAA, 32'h0, 1, 0);
        acc(0, 1, 0, W,  32'h22, 32'h0, 32'h0, 1, 1);
        acc(0, 1, 0, W,  32'h20, 32'h0, 32'h0, 0, 1);
        // illegal funct3 for store and load
        acc(0, 0, 1, BU, 32'h20, 32'h00000055, 32'h0, 1, 1);
        acc(0, 1, 0, W,  32'h20, 32'h0, 32'h0, 0, 1);
        acc(0, 1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
        acc(0, 1, 0, H,  32'h11, 32'h0, 32'h0, 1, 1);
        // wrap-around
        acc(0, 0, 1, W,  32'h400, 32'h12345678, 32'h0, 0, 1);
        acc(0, 1, 0, W,  32'h0,   32'h0, 32'h12345678, 0, 1);
        acc(0, 1, 0, BU, 32'h403, 32'h0, 32'h00000012, 0, 1);
        // combined load+store faults and writes nothing
        acc(0, 1, 1, W,  32'h30, 32'hCAFEF00D, 32'h0, 1, 1);
        acc(0, 1, 0, W,  32'h30, 32'h0, 32'h0, 0, 1);
        acc(0, 0, 1, W,  32'h30, 32'h0BADF00D, 32'h0, 0, 1);
        acc(0, 1, 0, W,  32'h30, 32'h0, 32'h0BADF00D, 0, 1);
        acc(0, 0, 1, H,  32'h32, 32'h1234BEEF, 32'h0, 0, 1);
        acc(0, 1, 0, W,  32'h30, 32'h0, 32'hBEEFF00D, 0, 1);
        acc(0, 1, 0, H,  32'h32, 32'h0, 32'hFFFFBEEF, 0, 1);
        acc(0, 1, 0, HU, 32'h32, 32'h0, 32'h0000BEEF, 0, 1);
        // reset mid-operation with a store in the reset cycle
        acc(0, 0, 1, W,  32'h0, 32'h11111111, 32'h0, 0, 1);
        acc(0, 0, 1, W,  32'h4, 32'h22222222, 32'h0, 0, 1);
        acc(0, 0, 1, W,  32'h8, 32'h33333333, 32'h0, 0, 1);
        acc(0, 0, 1, W,  32'hC, 32'h44444444, 32'h0, 0, 1);
        acc(0, 1, 0, W,  32'h8, 32'h0, 32'h33333333, 0, 1);
        acc(1, 0, 1, W,  32'h0, 32'hFFFFFFFF, 32'h0, 0, 1);
        acc(0, 1, 0, W,  32'h0,  32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h4,  32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h8,  32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'hC,  32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h10, 32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h30, 32'h0, 32'h0, 0, 0);
        // load during reset reads zero even over live data
        acc(0, 0, 1, W,  32'h4, 32'h55555555, 32'h0, 0, 0);
        acc(1, 1, 0, W,  32'h4, 32'h0, 32'h0, 0, 0);
        acc(0, 1, 0, W,  32'h4, 32'h0, 32'h0, 0, 0);

        @(posedge clk);
        #1;
        load_mem  = 1'b0;
        store_mem = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
